zephyr_loader: RTL and testbench

Program loader for the zephyr CPU: accepts a byte stream over a valid/ready interface and writes it sequentially into the 16×8 program RAM through the RAM write port. It holds the CPU in reset while loading and releases it once the image is complete. It is the writer side of program memory, whose reader is the CPU's fetch path. It sits between the host/debug link and `ram_inst`, alongside `zephyr`.

---
 rtl/zephyr_pkg.sv | 16 +
 rtl/zephyr_loader_if.sv | 26 ++
 rtl/zephyr_loader.sv | 183 ++++++++++++++++++
 tb/tb_zephyr_loader.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zephyr_pkg.sv
// Shared zephyr constants and the program-loader state encoding.
// Used by the loader, the program RAM and the CPU.
package zephyr_pkg;

    localparam int ZEPHYR_DEPTH  = 16;
    localparam int ZEPHYR_ADDR_W = 4;
    localparam int ZEPHYR_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FAIL = 2'd3
    } loader_state_e;

endpackage

// File: rtl/zephyr_loader_if.sv
// Byte-stream input and RAM write port of the zephyr program loader.
// The loader sits on the slave modport; host link and RAM sit on master.
interface zephyr_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) ();

    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] IN_DATA;
    logic              IN_LAST;
    logic              RAM_WE;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic [DATA_W-1:0] RAM_WDATA;

    modport slave (
        input  IN_VALID, IN_DATA, IN_LAST,
        output IN_READY, RAM_WE, RAM_ADDR, RAM_WDATA
    );

    modport master (
        output IN_VALID, IN_DATA, IN_LAST,
        input  IN_READY, RAM_WE, RAM_ADDR, RAM_WDATA
    );

endinterface

// File: rtl/zephyr_loader.sv
// Streams a program image into the zephyr RAM while holding the CPU in reset.
// Define ZEPHYR_LOADER_CHECKSUM_EN to require a trailing mod-2^DATA_W checksum byte.
module zephyr_loader
    import zephyr_pkg::*;
#(
    parameter int DEPTH  = ZEPHYR_DEPTH,
    parameter int ADDR_W = ZEPHYR_ADDR_W,
    parameter int DATA_W = ZEPHYR_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    zephyr_loader_if.slave    bus,
    output logic              CPU_RESET,
    output logic              DONE,
    output logic              ERROR,
    output logic [ADDR_W:0]   COUNT
);

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              hs;

`ifdef ZEPHYR_LOADER_CHECKSUM_EN
    localparam logic [ADDR_W:0] FULL_PTR = (ADDR_W+1)'(DEPTH);

    logic              error_q, error_d;
    logic [DATA_W-1:0] sum_q, sum_d;

    function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] b);
        return acc + b;
    endfunction
`else
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
`endif

    // count_q doubles as the write pointer; it never exceeds DEPTH
    assign hs = bus.IN_VALID & in_ready_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        in_ready_d  = in_ready_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
`ifdef ZEPHYR_LOADER_CHECKSUM_EN
        error_d     = error_q;
        sum_d       = sum_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cpu_reset_d = 1'b1;
                if (START) begin
                    state_d    = ST_LOAD;
                    count_d    = '0;
                    in_ready_d = 1'b1;
`ifdef ZEPHYR_LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            ST_LOAD: begin
                cpu_reset_d = 1'b1;
                done_d      = 1'b0;
`ifdef ZEPHYR_LOADER_CHECKSUM_EN
                error_d     = 1'b0;
                if (hs) begin
                    if (bus.IN_LAST || count_q == FULL_PTR) begin
                        in_ready_d = 1'b0;
                        state_d    = (bus.IN_DATA == sum_q) ? ST_RUN : ST_FAIL;
                    end else begin
                        ram_we_d    = 1'b1;
                        ram_addr_d  = count_q[ADDR_W-1:0];
                        ram_wdata_d = bus.IN_DATA;
                        count_d     = count_q + 1'b1;
                        sum_d       = csum_add(sum_q, bus.IN_DATA);
                    end
                end
`else
                if (hs) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = count_q[ADDR_W-1:0];
                    ram_wdata_d = bus.IN_DATA;
                    count_d     = count_q + 1'b1;
                    if (bus.IN_LAST || count_q == LAST_PTR) begin
                        in_ready_d = 1'b0;
                        state_d    = ST_RUN;
                    end
                end
`endif
            end
            ST_RUN: begin
                // CPU_RESET drops one cycle after entering RUN, i.e. after the last RAM_WE
                cpu_reset_d = 1'b0;
                done_d      = 1'b1;
                in_ready_d  = 1'b0;
                if (START) begin
                    state_d     = ST_LOAD;
                    count_d     = '0;
                    in_ready_d  = 1'b1;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
`ifdef ZEPHYR_LOADER_CHECKSUM_EN
                    sum_d       = '0;
`endif
                end
            end
`ifdef ZEPHYR_LOADER_CHECKSUM_EN
            ST_FAIL: begin
                cpu_reset_d = 1'b1;
                error_d     = 1'b1;
                in_ready_d  = 1'b0;
                if (START) begin
                    state_d    = ST_LOAD;
                    count_d    = '0;
                    in_ready_d = 1'b1;
                    error_d    = 1'b0;
                    sum_d      = '0;
                end
            end
`endif
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b0;
                cpu_reset_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
`ifdef ZEPHYR_LOADER_CHECKSUM_EN
            error_q     <= 1'b0;
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
`ifdef ZEPHYR_LOADER_CHECKSUM_EN
            error_q     <= error_d;
            sum_q       <= sum_d;
`endif
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.RAM_WE    = ram_we_q;
    assign bus.RAM_ADDR  = ram_addr_q;
    assign bus.RAM_WDATA = ram_wdata_q;
    assign CPU_RESET     = cpu_reset_q;
    assign DONE          = done_q;
    assign COUNT         = count_q;
`ifdef ZEPHYR_LOADER_CHECKSUM_EN
    assign ERROR         = error_q;
`else
    assign ERROR         = 1'b0;
`endif

endmodule

// File: tb/tb_zephyr_loader.sv
// Directed bench for zephyr_loader: full/short images, gaps, mid-load reset, reload
// and, when ZEPHYR_LOADER_CHECKSUM_EN is defined, checksum pass/fail.
module tb_zephyr_loader;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
`ifdef ZEPHYR_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              START = 1'b0;
    logic              CPU_RESET, DONE, ERROR;
    logic [ADDR_W:0]   COUNT;

    zephyr_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    zephyr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .bus(bus),
        .CPU_RESET(CPU_RESET), .DONE(DONE), .ERROR(ERROR), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DATA_W-1:0] ram [DEPTH];
    int                log_addr[$];
    logic [DATA_W-1:0] log_data[$];
    logic [DATA_W-1:0] img [DEPTH];
    int                img_n;
    logic [DATA_W-1:0] full_tbl [DEPTH] = '{8'h4C, 8'h5D, 8'h6E, 8'h7F, 8'h8F, 8'h9E, 8'hAD, 8'hBC,
                                            8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFA, 8'hDA, 8'hD0};

    always @(posedge CLK) cyc <= cyc + 1;

    // Acts as the program RAM and records every write strobe
    always @(negedge CLK) begin
        if (bus.RAM_WE === 1'b1) begin
            ram[bus.RAM_ADDR] <= bus.RAM_WDATA;
            log_addr.push_back(int'(bus.RAM_ADDR));
            log_data.push_back(bus.RAM_WDATA);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic send_byte(input logic [DATA_W-1:0] d, input logic last);
        int n = 0;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = d;
        bus.IN_LAST  = last;
        while (bus.IN_READY !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL handshake_timeout in_ready=%b required=1", bus.IN_READY);
        end
        step();
        bus.IN_VALID = 1'b0;
        bus.IN_LAST  = 1'b0;
        bus.IN_DATA  = 8'hXX;
    endtask

    // Sends img[0..img_n-1]; with checksum enabled a trailing sum byte is appended.
    task automatic send_image(input bit use_last);
        logic [DATA_W-1:0] s = '0;
        for (int i = 0; i < img_n; i++) begin
            send_byte(img[i], use_last && !CK && (i == img_n - 1));
            s = s + img[i];
        end
        if (CK) send_byte(s, use_last);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) step();
        total++;
        if ({CPU_RESET, bus.IN_READY, bus.RAM_WE, DONE, ERROR} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b required=10000",
                     {CPU_RESET, bus.IN_READY, bus.RAM_WE, DONE, ERROR});
        end
        total++;
        if ({bus.RAM_ADDR, bus.RAM_WDATA, COUNT} !== '0) begin
            bad++;
            $display("FAIL reset_data addr=%0d wdata=%h count=%0d required=0",
                     bus.RAM_ADDR, bus.RAM_WDATA, COUNT);
        end
        RESET_N = 1'b1;
        repeat (2) step();
        total++;
        if (bus.IN_READY !== 1'b0 || CPU_RESET !== 1'b1) begin
            bad++;
            $display("FAIL idle_hold ready=%b cpu_reset=%b required 0/1", bus.IN_READY, CPU_RESET);
        end
    endtask

    task automatic test_full_image();
        int c0;
        clear_log();
        for (int i = 0; i < DEPTH; i++) img[i] = full_tbl[i];
        img_n = DEPTH;
        pulse_start();
        total++;
        if (bus.IN_READY !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_start got=%b required=1", bus.IN_READY);
        end
        c0 = cyc;
        send_image(1'b0);
        total++;
        if (cyc - c0 != img_n + int'(CK)) begin
            bad++;
            $display("FAIL full_throughput cycles=%0d required=%0d", cyc - c0, img_n + int'(CK));
        end
`ifndef ZEPHYR_LOADER_CHECKSUM_EN
        total++;
        if ({bus.RAM_WE, bus.RAM_ADDR, bus.RAM_WDATA} !== {1'b1, 4'd15, 8'hD0}) begin
            bad++;
            $display("FAIL last_write we=%b addr=%0d data=%h required 1/15/d0",
                     bus.RAM_WE, bus.RAM_ADDR, bus.RAM_WDATA);
        end
`endif
        total++;
        if (CPU_RESET !== 1'b1 || bus.IN_READY !== 1'b0 || DONE !== 1'b0) begin
            bad++;
            $display("FAIL end_of_load cpu_reset=%b ready=%b done=%b required 1/0/0",
                     CPU_RESET, bus.IN_READY, DONE);
        end
        step();
        total++;
        if (CPU_RESET !== 1'b0 || DONE !== 1'b1) begin
            bad++;
            $display("FAIL release cpu_reset=%b done=%b required 0/1", CPU_RESET, DONE);
        end
        total++;
        if (COUNT !== 5'd16 || log_addr.size() != 16) begin
            bad++;
            $display("FAIL full_count count=%0d writes=%0d required 16/16", COUNT, log_addr.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (log_addr[i] != i || log_data[i] !== full_tbl[i]) begin
                    bad++;
                    $display("FAIL full_write[%0d] addr=%0d data=%h required %0d/%h",
                             i, log_addr[i], log_data[i], i, full_tbl[i]);
                end
            end
        end
    endtask

    task automatic test_reload_short();
        clear_log();
        pulse_start();
        total++;
        if (CPU_RESET !== 1'b1 || DONE !== 1'b0) begin
            bad++;
            $display("FAIL reload_reassert cpu_reset=%b done=%b required 1/0", CPU_RESET, DONE);
        end
        img[0] = 8'h4F; img[1] = 8'h8D; img[2] = 8'h5E; img[3] = 8'h9C;
        img_n = 4;
        send_image(1'b1);
        step();
        total++;
        if (COUNT !== 5'd4 || log_addr.size() != 4 || DONE !== 1'b1 || ERROR !== 1'b0) begin
            bad++;
            $display("FAIL short_done count=%0d writes=%0d done=%b error=%b required 4/4/1/0",
                     COUNT, log_addr.size(), DONE, ERROR);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (log_addr[i] != i || log_data[i] !== img[i]) begin
                    bad++;
                    $display("FAIL short_write[%0d] addr=%0d data=%h required %0d/%h",
                             i, log_addr[i], log_data[i], i, img[i]);
                end
            end
        end
        for (int i = 4; i < DEPTH; i++) begin
            total++;
            if (ram[i] !== full_tbl[i]) begin
                bad++;
                $display("FAIL ram_kept[%0d] got=%h required=%h", i, ram[i], full_tbl[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        pulse_start();
        START = 1'b1;
        bus.IN_VALID = 1'b1; bus.IN_DATA = 8'h11; bus.IN_LAST = 1'b0;
        step();
        START = 1'b0;
        bus.IN_VALID = 1'b0; bus.IN_DATA = 8'hEE; bus.IN_LAST = 1'b1;
        step();
        step();
        bus.IN_VALID = 1'b1; bus.IN_DATA = 8'h22; bus.IN_LAST = !CK;
        step();
        bus.IN_VALID = 1'b0; bus.IN_LAST = 1'b0;
        if (CK) send_byte(8'h33, 1'b1);
        step();
        step();
        total++;
        if (log_addr.size() != 2 || COUNT !== 5'd2 || DONE !== 1'b1) begin
            bad++;
            $display("FAIL gap_writes writes=%0d count=%0d done=%b required 2/2/1",
                     log_addr.size(), COUNT, DONE);
        end else begin
            total++;
            if (log_addr[0] != 0 || log_data[0] !== 8'h11 || log_addr[1] != 1 || log_data[1] !== 8'h22) begin
                bad++;
                $display("FAIL gap_order got %0d/%h %0d/%h required 0/11 1/22",
                         log_addr[0], log_data[0], log_addr[1], log_data[1]);
            end
        end
    endtask

    task automatic test_reset_midload();
        clear_log();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b0);
        step();
        total++;
        if (log_addr.size() != 5 || COUNT !== 5'd5 || bus.IN_READY !== 1'b1) begin
            bad++;
            $display("FAIL midload_pre writes=%0d count=%0d ready=%b required 5/5/1",
                     log_addr.size(), COUNT, bus.IN_READY);
        end
        RESET_N = 1'b0;
        #1;
        total++;
        if ({CPU_RESET, bus.IN_READY, bus.RAM_WE, DONE} !== 4'b1000 || COUNT !== '0) begin
            bad++;
            $display("FAIL midload_abort ctrl=%b count=%0d required 1000/0",
                     {CPU_RESET, bus.IN_READY, bus.RAM_WE, DONE}, COUNT);
        end
        #3;
        RESET_N = 1'b1;
        step();
        pulse_start();
        send_byte(8'h77, !CK);
        if (CK) send_byte(8'h77, 1'b1);
        step();
        total++;
        if (log_addr.size() != 6 || log_addr[log_addr.size()-1] != 0 ||
            log_data[log_data.size()-1] !== 8'h77) begin
            bad++;
            $display("FAIL restart_addr writes=%0d last_addr=%0d last_data=%h required 6/0/77",
                     log_addr.size(), log_addr[log_addr.size()-1], log_data[log_data.size()-1]);
        end
    endtask

`ifdef ZEPHYR_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        clear_log();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        step();
        step();
        total++;
        if (log_addr.size() != 2 || COUNT !== 5'd2 || DONE !== 1'b1 || ERROR !== 1'b0 || CPU_RESET !== 1'b0) begin
            bad++;
            $display("FAIL ck_match writes=%0d count=%0d done=%b error=%b cpu_reset=%b required 2/2/1/0/0",
                     log_addr.size(), COUNT, DONE, ERROR, CPU_RESET);
        end
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h04, 1'b1);
        step();
        step();
        total++;
        if (ERROR !== 1'b1 || CPU_RESET !== 1'b1 || DONE !== 1'b0 || bus.IN_READY !== 1'b0) begin
            bad++;
            $display("FAIL ck_mismatch error=%b cpu_reset=%b done=%b ready=%b required 1/1/0/0",
                     ERROR, CPU_RESET, DONE, bus.IN_READY);
        end
        pulse_start();
        total++;
        if (ERROR !== 1'b0 || bus.IN_READY !== 1'b1) begin
            bad++;
            $display("FAIL ck_clear error=%b ready=%b required 0/1", ERROR, bus.IN_READY);
        end
        send_byte(8'h00, 1'b1);
        step();
        step();
        total++;
        if (DONE !== 1'b1 || COUNT !== 5'd0) begin
            bad++;
            $display("FAIL ck_empty done=%b count=%0d required 1/0", DONE, COUNT);
        end
    endtask
`else
    task automatic test_last_is_data();
        clear_log();
        pulse_start();
        send_byte(8'hAB, 1'b1);
        step();
        total++;
        if (log_addr.size() != 1 || log_data[0] !== 8'hAB || DONE !== 1'b1 || ERROR !== 1'b0) begin
            bad++;
            $display("FAIL last_is_data writes=%0d data=%h done=%b error=%b required 1/ab/1/0",
                     log_addr.size(), log_data[0], DONE, ERROR);
        end
    endtask
`endif

    initial begin
        bus.IN_VALID = 1'b0;
        bus.IN_DATA  = '0;
        bus.IN_LAST  = 1'b0;
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'h55;
        test_reset();
        test_full_image();
        test_reload_short();
        test_backpressure();
        test_reset_midload();
`ifdef ZEPHYR_LOADER_CHECKSUM_EN
        test_checksum();
`else
        test_last_is_data();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
